// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Contents: master_e (M0 = processor data port, M1 = loader/debug master),
//           mem_req_t (one master's request fields), STAT_W (statistics counter width).
package dmem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STAT_W = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              lock;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_rsp.sv
// rtl/dmem_arb_rsp.sv - per-master registered read response and error pulse
// Ports: clk, reset_n (async active-low); gnt/we/legal describe this master's access
//        in the current cycle; rd is the memory read data; rvalid/rdata/err are the
//        registered responses presented one cycle after the grant.
module dmem_arb_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          gnt,
    input  logic          we,
    input  logic          legal,
    input  logic [DW-1:0] rd,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          err
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= gnt & ~we;
            err    <= gnt & ~legal;
            // Illegal reads still complete, but return zero instead of aliased data.
            if (gnt && !we) begin
                rdata <= legal ? rd : '0;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter for the single-port data memory
// Ports: clk, reset_n (async active-low);
//        mN_req/we/addr/wdata/lock in, mN_gnt (comb), mN_rvalid/rdata/err (registered), N=0,1;
//        mem_we/mem_a/mem_wd to dmem, mem_rd from dmem (combinational read);
//        stat_gnt0/stat_gnt1/stat_conflict only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int BURST_MAX   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conflict
`endif
);

    localparam int            BW        = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
    localparam logic [AW-3:0] DEPTH_IDX = (AW-2)'(DEPTH_WORDS);

    master_e       last_q;
    master_e       winner;
    master_e       other;
    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_nxt;
    logic [AW-1:0] a_q;
    logic [DW-1:0] wd_q;
    logic          both_req;
    logic          any_gnt;
    logic          owner_lock;
    logic          legal;
    mem_req_t      m0_r;
    mem_req_t      m1_r;
    mem_req_t      win_r;

    always_comb begin
        m0_r       = '{we: m0_we, addr: ADDR_W'(m0_addr), wdata: DATA_W'(m0_wdata), lock: m0_lock};
        m1_r       = '{we: m1_we, addr: ADDR_W'(m1_addr), wdata: DATA_W'(m1_wdata), lock: m1_lock};
        both_req   = m0_req & m1_req;
        // No grant can be issued while reset is held, so no write slips through.
        any_gnt    = (m0_req | m1_req) & reset_n;
        other      = (last_q == M0) ? M1 : M0;
        owner_lock = (last_q == M0) ? m0_lock : m1_lock;

        // The owner keeps the memory only while it locks and the burst cap is not hit;
        // otherwise the master that did not go last gets its turn.
        if (both_req) begin
            winner = (owner_lock && (burst_q < BURST_LIM)) ? last_q : other;
        end else if (m0_req) begin
            winner = M0;
        end else begin
            winner = M1;
        end

        win_r = (winner == M0) ? m0_r : m1_r;
        legal = (win_r.addr[1:0] == 2'b00) && (win_r.addr[AW-1:2] < DEPTH_IDX);

        if (!win_r.lock) begin
            burst_nxt = '0;
        end else if (winner != last_q) begin
            burst_nxt = BW'(1);
        end else if (burst_q == BURST_LIM) begin
            burst_nxt = burst_q;
        end else begin
            burst_nxt = burst_q + BW'(1);
        end
    end

    assign m0_gnt = any_gnt & (winner == M0);
    assign m1_gnt = any_gnt & (winner == M1);
    assign mem_we = any_gnt & win_r.we & legal;
    assign mem_a  = any_gnt ? win_r.addr[AW-1:0] : a_q;
    assign mem_wd = any_gnt ? win_r.wdata[DW-1:0] : wd_q;

    // Reset leaves last=M1 so that M0 wins the first conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= M1;
            burst_q <= '0;
            a_q     <= '0;
            wd_q    <= '0;
        end else if (any_gnt) begin
            last_q  <= winner;
            burst_q <= burst_nxt;
            a_q     <= win_r.addr[AW-1:0];
            wd_q    <= win_r.wdata[DW-1:0];
        end
    end

    dmem_arb_rsp #(.DW(DW)) u_rsp0 (
        .clk     (clk),
        .reset_n (reset_n),
        .gnt     (m0_gnt),
        .we      (m0_we),
        .legal   (legal),
        .rd      (mem_rd),
        .rvalid  (m0_rvalid),
        .rdata   (m0_rdata),
        .err     (m0_err)
    );

    dmem_arb_rsp #(.DW(DW)) u_rsp1 (
        .clk     (clk),
        .reset_n (reset_n),
        .gnt     (m1_gnt),
        .we      (m1_we),
        .legal   (legal),
        .rd      (mem_rd),
        .rvalid  (m1_rvalid),
        .rdata   (m1_rdata),
        .err     (m1_err)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] g0_q;
    logic [STAT_W-1:0] g1_q;
    logic [STAT_W-1:0] cf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g0_q <= '0;
            g1_q <= '0;
            cf_q <= '0;
        end else begin
            if (m0_gnt && (g0_q != '1)) g0_q <= g0_q + STAT_W'(1);
            if (m1_gnt && (g1_q != '1)) g1_q <= g1_q + STAT_W'(1);
            if (both_req && (cf_q != '1)) cf_q <= cf_q + STAT_W'(1);
        end
    end

    assign stat_gnt0     = g0_q;
    assign stat_gnt1     = g1_q;
    assign stat_conflict = cf_q;
`else
    // Statistics counters are not built; arbitration above is unaffected.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        init_mem;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    logic [31:0] mem [0:63];
    int          vectors;
    int          miscompares;

    dmem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
`endif
    );

    // Behavioural dmem: combinational read, write on the clock edge.
    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    initial begin
        logic exp1;
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        init_mem = 1'b1;
        drive0(1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state: grants and writes are suppressed while reset is held.
        #2;
        chk("rst_gnt0", m0_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid0", m0_rvalid, 0);
        chk("rst_err0", m0_err, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rvalid1", m1_rvalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        reset_n = 1'b1;
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // 1: write then read back through M0.
        @(negedge clk);
        drive0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        #2;
        chk("t1_wr_gnt0", m0_gnt, 1);
        chk("t1_wr_gnt1", m1_gnt, 0);
        chk("t1_wr_mem_we", mem_we, 1);
        chk("t1_wr_mem_a", mem_a, 32'h10);
        chk("t1_wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("t1_wr_rvalid", m0_rvalid, 0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        #2;
        chk("t1_rd_gnt0", m0_gnt, 1);
        chk("t1_rd_mem_we", mem_we, 0);
        @(posedge clk); #1;
        chk("t1_rd_rvalid", m0_rvalid, 1);
        chk("t1_rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("t1_idle_gnt0", m0_gnt, 0);
        chk("t1_idle_mem_a_hold", mem_a, 32'h10);
        @(posedge clk); #1;
        chk("t1_idle_rvalid", m0_rvalid, 0);
        chk("t1_idle_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // 2: both request, no lock -> alternate, starting with M1 (M0 went last).
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        drive1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            exp1 = (k % 2 == 0);
            #2;
            chk($sformatf("t2_gnt1_%0d", k), m1_gnt, 32'(exp1));
            chk($sformatf("t2_gnt0_%0d", k), m0_gnt, 32'(!exp1));
            @(posedge clk); #1;
            chk($sformatf("t2_rvalid1_%0d", k), m1_rvalid, 32'(exp1));
            chk($sformatf("t2_rvalid0_%0d", k), m0_rvalid, 32'(!exp1));
        end
        chk("t2_rdata1", m1_rdata, 32'h1000_0001);
        chk("t2_rdata0", m0_rdata, 32'h1000_0000);
`ifdef DMEM_ARB_STATS_EN
        chk("t2_stat_conflict", stat_conflict, 4);
`endif

        // 3: M1 locks while M0 waits -> four M1 grants, then M0.
        @(negedge clk);
        m1_lock = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            chk($sformatf("t3_gnt1_%0d", k), m1_gnt, (k < 4) ? 1 : 0);
            chk($sformatf("t3_gnt0_%0d", k), m0_gnt, (k < 4) ? 0 : 1);
            @(posedge clk);
        end
        // Lock with the other master idle is never capped.
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            chk($sformatf("t3_solo_gnt1_%0d", k), m1_gnt, 1);
            @(posedge clk);
        end

        // 4: out-of-range and misaligned accesses, plus the last legal word.
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive0(1'b1, 1'b1, 32'h100, 32'h55, 1'b0);
        #2;
        chk("t4_wr_gnt0", m0_gnt, 1);
        chk("t4_wr_mem_we", mem_we, 0);
        @(posedge clk); #1;
        chk("t4_wr_err", m0_err, 1);
        chk("t4_wr_rvalid", m0_rvalid, 0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h102, 32'h0, 1'b0);
        #2;
        chk("t4_rd_gnt0", m0_gnt, 1);
        chk("t4_rd_mem_we", mem_we, 0);
        @(posedge clk); #1;
        chk("t4_rd_err", m0_err, 1);
        chk("t4_rd_rvalid", m0_rvalid, 1);
        chk("t4_rd_rdata", m0_rdata, 0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("t4_top_err", m0_err, 0);
        chk("t4_top_rvalid", m0_rvalid, 1);
        chk("t4_top_rdata", m0_rdata, 32'h1000_003F);
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("t4_idle_err", m0_err, 0);
        chk("t4_idle_rvalid", m0_rvalid, 0);
        chk("t4_word0_intact", mem[0], 32'h1000_0000);

        // 5: reset during an M1 write; pending M0 read response is dropped.
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("t5_pre_rvalid", m0_rvalid, 1);
        chk("t5_pre_rdata", m0_rdata, 32'h1000_0002);
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive1(1'b1, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b0);
        #1;
        chk("t5_pre_gnt1", m1_gnt, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_gnt1", m1_gnt, 0);
        chk("t5_rst_mem_we", mem_we, 0);
        chk("t5_rst_rvalid0", m0_rvalid, 0);
        chk("t5_rst_rdata0", m0_rdata, 0);
        @(posedge clk); #1;
        chk("t5_word2_intact", mem[2], 32'h1000_0002);
        chk("t5_rst_err1", m1_err, 0);
        chk("t5_rst_rvalid1", m1_rvalid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        drive1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        #2;
        chk("t5_first_gnt0", m0_gnt, 1);
        chk("t5_first_gnt1", m1_gnt, 0);
        @(posedge clk);

`ifdef DMEM_ARB_STATS_EN
        // 6: 10 M0 grants (one above plus nine solo) and 7 M1 grants since reset.
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        repeat (7) @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("t6_stat_gnt0", stat_gnt0, 10);
        chk("t6_stat_gnt1", stat_gnt1, 7);
        chk("t6_stat_conflict", stat_conflict, 1);
        force dut.g0_q = 32'hFFFF_FFFF;
        #1;
        release dut.g0_q;
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("t6_stat_gnt0_sat", stat_gnt0, 32'hFFFF_FFFF);
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
